// File: rtl/bus_decoder_if.sv
// Requester-side handshake bundle for the bus decoder.
// master drives the request, slave answers with completion and data.
interface bus_decoder_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32
);
   logic                  req_i;
   logic                  we_i;
   logic [ADDR_WIDTH-1:0] addr_i;
   logic [DATA_WIDTH-1:0] wdata_i;
   logic                  ready_o;
   logic                  err_o;
   logic [DATA_WIDTH-1:0] rdata_o;
   logic                  busy_o;

   modport master (
      output req_i, we_i, addr_i, wdata_i,
      input  ready_o, err_o, rdata_o, busy_o
   );

   modport slave (
      input  req_i, we_i, addr_i, wdata_i,
      output ready_o, err_o, rdata_o, busy_o
   );
endinterface

// File: rtl/bus_decoder.sv
// Address decoder with per-region wait states bridging one requester
// to four memory-mapped targets (RAM, UART, GPIO, ROM).
module bus_decoder #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter logic [31:0] ROM_BASE   = 32'h0040_0000,
   parameter logic [31:0] RAM_BASE   = 32'h1001_0000,
   parameter logic [31:0] GPIO_BASE  = 32'h1001_1024,
   parameter logic [31:0] UART_BASE  = 32'h1001_102C,
   parameter logic [31:0] UART_TOP   = 32'h1001_1040,
   parameter int unsigned WS_ROM     = 0,
   parameter int unsigned WS_RAM     = 1,
   parameter int unsigned WS_GPIO    = 0,
   parameter int unsigned WS_UART    = 3
) (
   input  logic                    clk,
   input  logic                    reset,
   bus_decoder_if.slave            bus,
   output logic [3:0]              tgt_en_o,
   output logic                    tgt_we_o,
   output logic [ADDR_WIDTH-1:0]   tgt_addr_o,
   output logic [DATA_WIDTH-1:0]   tgt_wdata_o,
   output logic [1:0]              sel_o,
   input  logic [4*DATA_WIDTH-1:0] tgt_rdata_i
);
   localparam logic [ADDR_WIDTH-1:0] ROM_B  = ADDR_WIDTH'(ROM_BASE);
   localparam logic [ADDR_WIDTH-1:0] RAM_B  = ADDR_WIDTH'(RAM_BASE);
   localparam logic [ADDR_WIDTH-1:0] GPIO_B = ADDR_WIDTH'(GPIO_BASE);
   localparam logic [ADDR_WIDTH-1:0] UART_B = ADDR_WIDTH'(UART_BASE);
   localparam logic [ADDR_WIDTH-1:0] TOP_B  = ADDR_WIDTH'(UART_TOP);
   localparam logic [3:0] W_ROM  = 4'(WS_ROM);
   localparam logic [3:0] W_RAM  = 4'(WS_RAM);
   localparam logic [3:0] W_GPIO = 4'(WS_GPIO);
   localparam logic [3:0] W_UART = 4'(WS_UART);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t                state, state_n;
   logic [3:0]            cnt;
   logic                  we;
   logic                  err;
   logic [1:0]            sel;
   logic [ADDR_WIDTH-1:0] offset;
   logic [DATA_WIDTH-1:0] wdata;
   logic [DATA_WIDTH-1:0] rdata;
   logic [DATA_WIDTH-1:0] rd_slice;

   logic                  dec_hit;
   logic                  dec_err;
   logic [1:0]            dec_sel;
   logic [ADDR_WIDTH-1:0] dec_base;
   logic [3:0]            dec_ws;
   logic [ADDR_WIDTH-1:0] a;

   assign a = bus.addr_i;

   // Regions are disjoint, so at most one arm can match
   always_comb begin
      dec_hit  = 1'b1;
      dec_sel  = 2'd0;
      dec_base = '0;
      dec_ws   = '0;
      unique case (1'b1)
         (a >= UART_B && a < TOP_B): begin
            dec_sel  = 2'd1;
            dec_base = UART_B;
            dec_ws   = W_UART;
         end
         (a >= GPIO_B && a < UART_B): begin
            dec_sel  = 2'd2;
            dec_base = GPIO_B;
            dec_ws   = W_GPIO;
         end
         (a >= RAM_B && a < GPIO_B): begin
            dec_sel  = 2'd0;
            dec_base = RAM_B;
            dec_ws   = W_RAM;
         end
         (a >= ROM_B && a < RAM_B): begin
            dec_sel  = 2'd3;
            dec_base = ROM_B;
            dec_ws   = W_ROM;
         end
         default: dec_hit = 1'b0;
      endcase
   end

   assign dec_err = !dec_hit || (a[1:0] != 2'b00) ||
                    (bus.we_i && dec_sel == 2'd3);

   always_comb begin
      rd_slice = '0;
      for (int k = 0; k < 4; k++)
         if (sel == 2'(k))
            rd_slice = tgt_rdata_i[k*DATA_WIDTH +: DATA_WIDTH];
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (bus.req_i) state_n = dec_err ? DONE : ACCESS;
         ACCESS:  if (cnt == 4'd0) state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         cnt    <= '0;
         we     <= 1'b0;
         err    <= 1'b0;
         sel    <= '0;
         offset <= '0;
         wdata  <= '0;
         rdata  <= '0;
      end else begin
         state <= state_n;
         unique case (state)
            IDLE: if (bus.req_i) begin
               err <= dec_err;
               if (dec_err) begin
                  rdata <= '0;
               end else begin
                  sel    <= dec_sel;
                  we     <= bus.we_i;
                  offset <= a - dec_base;
                  wdata  <= bus.wdata_i;
                  cnt    <= dec_ws;
               end
            end
            ACCESS: begin
               if (cnt != 4'd0) cnt <= cnt - 4'd1;
               else rdata <= we ? '0 : rd_slice;
            end
            default: ;
         endcase
      end
   end

   assign tgt_en_o    = (state == ACCESS) ? (4'b0001 << sel) : 4'b0000;
   assign tgt_we_o    = (state == ACCESS) && we && (cnt == 4'd0);
   assign tgt_addr_o  = offset;
   assign tgt_wdata_o = wdata;
   assign sel_o       = sel;
   assign bus.ready_o = (state == DONE);
   assign bus.err_o   = (state == DONE) && err;
   assign bus.busy_o  = (state != IDLE);
   assign bus.rdata_o = rdata;
endmodule

// File: tb/tb_bus_decoder.sv
// Randomized and directed bench for bus_decoder against an
// address-map table model.
module tb_bus_decoder;
   localparam int DW = 32;
   localparam int AW = 32;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   bus_decoder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bif ();

   logic [3:0]      tgt_en;
   logic            tgt_we;
   logic [AW-1:0]   tgt_addr;
   logic [DW-1:0]   tgt_wdata;
   logic [1:0]      sel;
   logic [4*DW-1:0] tgt_rdata;

   bus_decoder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bif),
      .tgt_en_o    (tgt_en),
      .tgt_we_o    (tgt_we),
      .tgt_addr_o  (tgt_addr),
      .tgt_wdata_o (tgt_wdata),
      .sel_o       (sel),
      .tgt_rdata_i (tgt_rdata)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Address map indexed by select code: RAM, UART, GPIO, ROM
   logic [31:0] m_base [4] = '{32'h1001_0000, 32'h1001_102C,
                               32'h1001_1024, 32'h0040_0000};
   logic [31:0] m_top  [4] = '{32'h1001_1024, 32'h1001_1040,
                               32'h1001_102C, 32'h1001_0000};
   int          m_ws   [4] = '{1, 3, 0, 0};

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void model(input logic w, input logic [31:0] ad,
                                 output logic e, output int k,
                                 output logic [31:0] off);
      k = -1;
      for (int i = 0; i < 4; i++)
         if (ad >= m_base[i] && ad < m_top[i]) k = i;
      e = (k < 0) || (ad[1:0] != 2'b00) || (w && k == 3);
      off = (k < 0) ? 32'd0 : ad - m_base[k];
   endfunction

   task automatic run_txn(input logic w, input logic [31:0] ad,
                          input logic [31:0] d);
      logic        e;
      int          k;
      logic [31:0] off;
      logic [31:0] exp_rd;
      int          cyc, en_cyc, we_cnt, we_pos, en_bad;
      bit          got;
      model(w, ad, e, k, off);
      tgt_rdata = {$urandom, $urandom, $urandom, $urandom};
      exp_rd = (e || w) ? 32'd0 : tgt_rdata[k*DW +: DW];
      @(negedge clk);
      bif.req_i   = 1'b1;
      bif.we_i    = w;
      bif.addr_i  = ad;
      bif.wdata_i = d;
      @(posedge clk);
      cyc = 0; en_cyc = 0; we_cnt = 0; we_pos = 0; en_bad = 0;
      got = 0;
      while (!got && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) check("busy", bif.busy_o, 1);
         if (tgt_en != 4'b0000) begin
            en_cyc++;
            if (e || tgt_en != (4'b0001 << k)) en_bad++;
         end
         if (tgt_we) begin
            we_cnt++;
            we_pos = en_cyc;
         end
         if (bif.ready_o) got = 1;
      end
      check("latency", cyc, e ? 1 : m_ws[k] + 2);
      check("err", bif.err_o, e);
      check("rdata", bif.rdata_o, exp_rd);
      check("en_onehot", en_bad, 0);
      check("en_cycles", en_cyc, e ? 0 : m_ws[k] + 1);
      check("we_count", we_cnt, (w && !e) ? 1 : 0);
      if (!e) begin
         check("offset", tgt_addr, off);
         check("sel", sel, k);
         check("wdata", tgt_wdata, d);
         if (w) check("we_pos", we_pos, m_ws[k] + 1);
      end
      bif.req_i = 1'b0;
      @(negedge clk);
      check("ready_pulse", bif.ready_o, 0);
      check("idle", bif.busy_o, 0);
      check("rdata_hold", bif.rdata_o, exp_rd);
   endtask

   logic [31:0] ra;
   int          rk;
   int          ready_seen;

   initial begin
      bif.req_i   = 1'b0;
      bif.we_i    = 1'b0;
      bif.addr_i  = '0;
      bif.wdata_i = '0;
      tgt_rdata   = '0;
      repeat (3) @(negedge clk);
      check("rst_en", tgt_en, 0);
      check("rst_busy", bif.busy_o, 0);
      check("rst_ready", bif.ready_o, 0);
      check("rst_rdata", bif.rdata_o, 0);
      check("rst_addr", tgt_addr, 0);
      reset = 1'b1;
      @(negedge clk);

      run_txn(1'b0, 32'h1001_0008, 32'h0);
      run_txn(1'b1, 32'h1001_1030, 32'h55);
      run_txn(1'b1, 32'h0040_0010, 32'h1234);
      run_txn(1'b0, 32'h2000_0000, 32'h0);
      run_txn(1'b0, 32'h1001_0002, 32'h0);
      run_txn(1'b0, 32'h1001_1028, 32'h0);
      run_txn(1'b0, 32'h1001_1024, 32'h0);
      run_txn(1'b0, 32'h1001_102C, 32'h0);
      run_txn(1'b0, 32'h1001_1040, 32'h0);
      run_txn(1'b0, 32'h0040_0000, 32'h0);
      run_txn(1'b0, 32'h003F_FFFC, 32'h0);

      // Abort a UART read in its second cycle
      tgt_rdata = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      bif.req_i  = 1'b1;
      bif.we_i   = 1'b0;
      bif.addr_i = 32'h1001_1030;
      @(posedge clk);
      @(negedge clk);
      check("abort_en", tgt_en, 4'b0010);
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      check("abort_en0", tgt_en, 0);
      check("abort_busy", bif.busy_o, 0);
      check("abort_ready", bif.ready_o, 0);
      check("abort_sel", sel, 0);
      check("abort_addr", tgt_addr, 0);
      check("abort_rdata", bif.rdata_o, 0);
      @(negedge clk);
      bif.req_i = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      ready_seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (bif.ready_o) ready_seen++;
      end
      check("abort_noready", ready_seen, 0);
      run_txn(1'b0, 32'h1001_0008, 32'h0);

      for (int n = 0; n < 300; n++) begin
         case ($urandom_range(0, 5))
            0, 1, 2, 3: begin
               rk = $urandom_range(0, 3);
               ra = m_base[rk] + ($urandom % (m_top[rk] - m_base[rk]));
            end
            4: ra = $urandom;
            default: begin
               if ($urandom_range(0, 1) == 0)
                  ra = 32'h1001_1040 + $urandom_range(0, 15);
               else
                  ra = 32'h0040_0000 - $urandom_range(1, 16);
            end
         endcase
         if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
         run_txn(1'($urandom_range(0, 1)), ra, $urandom);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule
